// File: rtl/freq_calc_if.sv
// Count-pair in / frequency-result out bundle for freq_calc.
// master drives the gate counts; slave (freq_calc) returns the result and status.
interface freq_calc_if #(
  parameter int CNT_W = 32,
  parameter int OUT_W = 32
);
  logic             cnt_valid;
  logic [CNT_W-1:0] ref_cnt;
  logic [CNT_W-1:0] meas_cnt;
  logic [OUT_W-1:0] freq_out;
  logic             freq_valid;
  logic             busy;
  logic             div_err;
  logic             ovf;
  logic             overrun;

  modport master (
    output cnt_valid, ref_cnt, meas_cnt,
    input  freq_out, freq_valid, busy, div_err, ovf, overrun
  );

  modport slave (
    input  cnt_valid, ref_cnt, meas_cnt,
    output freq_out, freq_valid, busy, div_err, ovf, overrun
  );
endinterface

// File: rtl/freq_calc.sv
// Gate counts to frequency: freq = meas_cnt * F_REF_HZ / ref_cnt via a restoring divider.
// Define FREQ_ROUND_EN for round-half-up; the default build truncates toward zero.
module freq_calc #(
  parameter int unsigned F_REF_HZ = 10_000_000,
  parameter int          CNT_W    = 32,
  parameter int          OUT_W    = 32
) (
  input logic        clk_ref,
  input logic        sys_rstn,
  freq_calc_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for cnt_valid, counts latched on accept
  // LOAD  | numerator formed, divider cleared
  // DIV   | NUM_W restoring steps, one quotient bit per cycle MSB first
  // DONE  | result, div_err and ovf registered, freq_valid pulsed

  localparam int NUM_W  = CNT_W + 32;
  localparam int ITER_W = $clog2(NUM_W);
  localparam logic [NUM_W-1:0]  F_REF_N   = NUM_W'(F_REF_HZ);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(NUM_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

  state_t state;
  state_t state_nxt;

  logic             latch_en;
  logic             load_en;
  logic             step_en;
  logic             done_en;
  logic             busy_int;

  logic [CNT_W-1:0]  ref_lat;
  logic [CNT_W-1:0]  meas_lat;
  logic [NUM_W-1:0]  num;
  logic [NUM_W-1:0]  num_load;
  logic [NUM_W-1:0]  quo;
  logic [CNT_W:0]    rem;
  logic [CNT_W:0]    rem_shift;
  logic [CNT_W:0]    rem_sub;
  logic              sub_ok;
  logic [ITER_W-1:0] iter;
  logic              quo_hi;
  logic              zero_div;

  always_ff @(posedge clk_ref or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cnt_valid) state_nxt = LOAD;
      LOAD:    state_nxt = DIV;
      DIV:     if (iter == ITER_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    latch_en = 1'b0;
    load_en  = 1'b0;
    step_en  = 1'b0;
    done_en  = 1'b0;
    busy_int = 1'b1;
    case (state)
      IDLE: begin
        busy_int = 1'b0;
        latch_en = bus.cnt_valid;
      end
      LOAD:    load_en = 1'b1;
      DIV:     step_en = 1'b1;
      DONE:    done_en = 1'b1;
      default: busy_int = 1'b0;
    endcase
  end

  assign bus.busy = busy_int;

  always_comb begin
    num_load = NUM_W'(meas_lat) * F_REF_N;
`ifdef FREQ_ROUND_EN
    num_load = num_load + NUM_W'(ref_lat >> 1);
`endif
  end

  // The partial remainder never exceeds the divisor, but its guard bit still
  // forces a subtract so the step stays correct for any stored value.
  always_comb begin
    rem_shift = {rem[CNT_W-1:0], num[NUM_W-1]};
    rem_sub   = rem_shift - {1'b0, ref_lat};
    sub_ok    = rem[CNT_W] | (rem_shift >= {1'b0, ref_lat});
  end

  assign quo_hi   = (quo >> OUT_W) != '0;
  assign zero_div = (ref_lat == '0);

  always_ff @(posedge clk_ref or negedge sys_rstn) begin
    if (!sys_rstn) begin
      ref_lat  <= '0;
      meas_lat <= '0;
      num      <= '0;
      quo      <= '0;
      rem      <= '0;
      iter     <= '0;
    end else begin
      if (latch_en) begin
        ref_lat  <= bus.ref_cnt;
        meas_lat <= bus.meas_cnt;
      end
      if (load_en) begin
        num  <= num_load;
        quo  <= '0;
        rem  <= '0;
        iter <= '0;
      end
      if (step_en) begin
        num  <= num << 1;
        quo  <= {quo[NUM_W-2:0], sub_ok};
        rem  <= sub_ok ? rem_sub : rem_shift;
        iter <= iter + ITER_W'(1);
      end
    end
  end

  // Divide-by-zero still walks every step so latency never depends on the data.
  always_ff @(posedge clk_ref or negedge sys_rstn) begin
    if (!sys_rstn) begin
      bus.freq_out   <= '0;
      bus.freq_valid <= 1'b0;
      bus.div_err    <= 1'b0;
      bus.ovf        <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.freq_valid <= done_en;
      bus.overrun    <= bus.cnt_valid & busy_int;
      if (done_en) begin
        if (zero_div) begin
          bus.freq_out <= '1;
          bus.div_err  <= 1'b1;
          bus.ovf      <= 1'b0;
        end else if (quo_hi) begin
          bus.freq_out <= '1;
          bus.div_err  <= 1'b0;
          bus.ovf      <= 1'b1;
        end else begin
          bus.freq_out <= OUT_W'(quo);
          bus.div_err  <= 1'b0;
          bus.ovf      <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_freq_calc.sv
// Scoreboard bench for freq_calc: directed count pairs, results checked by a monitor.
// Honours FREQ_ROUND_EN for the rounding vector.
module tb_freq_calc;
  localparam int LAT = 66;
`ifdef FREQ_ROUND_EN
  localparam logic [31:0] ROUND_EXP = 32'd6_666_667;
`else
  localparam logic [31:0] ROUND_EXP = 32'd6_666_666;
`endif

  typedef struct {
    logic [31:0] freq;
    logic        de;
    logic        ov;
    int          acc;
  } exp_t;

  logic clk_ref;
  logic sys_rstn;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   ovr_cnt = 0;
  int   ovr_exp = 0;
  int   nvalid = 0;
  exp_t sb[$];
  exp_t mon_e;

  freq_calc_if #(.CNT_W(32), .OUT_W(32)) bus ();

  freq_calc #(.F_REF_HZ(10_000_000), .CNT_W(32), .OUT_W(32)) dut (
    .clk_ref (clk_ref),
    .sys_rstn(sys_rstn),
    .bus     (bus)
  );

  initial clk_ref = 1'b0;
  always #5 clk_ref = ~clk_ref;
  always @(posedge clk_ref) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_freq_out"}, 64'(bus.freq_out), 64'd0);
    check({tag, "_freq_valid"}, 64'(bus.freq_valid), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_div_err"}, 64'(bus.div_err), 64'd0);
    check({tag, "_ovf"}, 64'(bus.ovf), 64'd0);
    check({tag, "_overrun"}, 64'(bus.overrun), 64'd0);
  endtask

  // Call at a negedge; cnt_valid is sampled at the following posedge.
  task automatic send(input logic [31:0] r, input logic [31:0] m, input logic take,
                      input logic [31:0] f, input logic de, input logic ov, output int acc);
    exp_t e;
    bus.ref_cnt   = r;
    bus.meas_cnt  = m;
    bus.cnt_valid = 1'b1;
    @(posedge clk_ref);
    #1;
    bus.cnt_valid = 1'b0;
    acc = cyc;
    if (take) begin
      e.freq = f;
      e.de   = de;
      e.ov   = ov;
      e.acc  = acc;
      sb.push_back(e);
      check("busy_after_accept", 64'(bus.busy), 64'd1);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) return;
      @(negedge clk_ref);
    end
    check("result_timeout_pending", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk_ref) begin
    if (sys_rstn) begin
      if (bus.overrun) ovr_cnt++;
      if (bus.freq_valid) begin
        nvalid++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_freq_valid: got freq_out %0h, expected no result", bus.freq_out);
        end else begin
          mon_e = sb.pop_front();
          check("freq_out", 64'(bus.freq_out), 64'(mon_e.freq));
          check("div_err", 64'(bus.div_err), 64'(mon_e.de));
          check("ovf", 64'(bus.ovf), 64'(mon_e.ov));
          check("latency", 64'(cyc - mon_e.acc), 64'(LAT));
          check("busy_at_valid", 64'(bus.busy), 64'd0);
        end
      end
    end
  end

  initial begin
    int a0;
    int a1;
    int nv;
    sys_rstn      = 1'b0;
    bus.cnt_valid = 1'b0;
    bus.ref_cnt   = '0;
    bus.meas_cnt  = '0;
    repeat (3) @(negedge clk_ref);
    check_zero("reset");
    sys_rstn = 1'b1;
    @(negedge clk_ref);

    send(32'd10000, 32'd1000, 1'b1, 32'd1_000_000, 1'b0, 1'b0, a0);
    wait_done();
    @(negedge clk_ref);
    send(32'd3, 32'd2, 1'b1, ROUND_EXP, 1'b0, 1'b0, a0);
    wait_done();
    @(negedge clk_ref);
    send(32'd0, 32'd5, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, a0);
    wait_done();

    // second pair 10 cycles into the first is dropped
    @(negedge clk_ref);
    send(32'd10000, 32'd1000, 1'b1, 32'd1_000_000, 1'b0, 1'b0, a0);
    repeat (9) @(negedge clk_ref);
    send(32'd20000, 32'd500, 1'b0, 32'd0, 1'b0, 1'b0, a1);
    ovr_exp++;
    wait_done();
    check("overrun_count_mid", 64'(ovr_cnt), 64'(ovr_exp));

    // cnt_valid on the DONE edge is dropped; the next edge accepts
    @(negedge clk_ref);
    send(32'd20000, 32'd500, 1'b1, 32'd250_000, 1'b0, 1'b0, a0);
    while (cyc < a0 + LAT - 1) @(negedge clk_ref);
    send(32'd40000, 32'd1, 1'b0, 32'd0, 1'b0, 1'b0, a1);
    ovr_exp++;
    @(negedge clk_ref);
    check("valid_before_b2b", 64'(bus.freq_valid), 64'd1);
    send(32'd40000, 32'd3000, 1'b1, 32'd750_000, 1'b0, 1'b0, a1);
    check("b2b_accept_edge", 64'(a1 - a0), 64'(LAT + 1));
    wait_done();

    @(negedge clk_ref);
    send(32'd1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, a0);
    wait_done();

    // reset at DIV step 30 aborts the calculation
    @(negedge clk_ref);
    send(32'd10000, 32'd4000, 1'b1, 32'd4_000_000, 1'b0, 1'b0, a0);
    while (cyc < a0 + 32) @(negedge clk_ref);
    sys_rstn = 1'b0;
    #1;
    check_zero("midreset");
    void'(sb.pop_back());
    nv = nvalid;
    repeat (3) @(negedge clk_ref);
    sys_rstn = 1'b1;
    repeat (80) @(negedge clk_ref);
    check("no_valid_after_reset", 64'(nvalid - nv), 64'd0);
    check("freq_out_after_reset", 64'(bus.freq_out), 64'd0);

    send(32'd10000, 32'd2000, 1'b1, 32'd2_000_000, 1'b0, 1'b0, a0);
    wait_done();

    repeat (3) @(negedge clk_ref);
    check("overrun_count", 64'(ovr_cnt), 64'(ovr_exp));
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
